// File: rtl/msx_mem_arbiter.sv
// -----------------------------------------------------------------------------
// msx_mem_arbiter
//
// Serialises accesses from three requesters (CPU slot path, flash-emulation
// engine, media image loader) onto the single shared memory-controller port.
// One access is in flight at a time. The sequence is IDLE (select + latch),
// ISSUE (mem_ce strobe), WAIT (for mem_ack or timeout) and DONE (completion
// pulse to the owner).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cpu_req/addr/din/rnw        CPU request (level), address, write data, 1=read
//   cpu_dout, cpu_done          registered CPU read data, completion pulse
//   flash_req/addr/din          flash engine write request
//   flash_ready, flash_done     grant-accepted pulse (ISSUE), completion pulse
//   ld_req/addr/din, ld_done    loader write request, completion pulse
//   mem_ce                      one-cycle strobe to the controller
//   mem_addr/din/rnw            registered access attributes (stable ISSUE..DONE)
//   mem_dout, mem_ack           controller read data and completion pulse
//   busy                        high whenever the FSM is not in IDLE
//   err_timeout                 sticky: an access was aborted by timeout
//
// Arbitration: the CPU has fixed priority, but after STARVE_MAX consecutive CPU
// grants made while flash or loader were waiting, the CPU is skipped once.
// Flash and loader share a 1-bit round-robin pointer.
// -----------------------------------------------------------------------------
module msx_mem_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_rnw,
    output logic [7:0]        cpu_dout,
    output logic              cpu_done,

    input  logic              flash_req,
    input  logic [ADDR_W-1:0] flash_addr,
    input  logic [7:0]        flash_din,
    output logic              flash_ready,
    output logic              flash_done,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_din,
    output logic              ld_done,

    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_rnw,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,

    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_CPU   = 2'd0;
    localparam logic [1:0] OWN_FLASH = 2'd1;
    localparam logic [1:0] OWN_LD    = 2'd2;

    localparam logic [7:0]  STARVE_LIM  = 8'(STARVE_MAX);
    // The abort fires in the TIMEOUT-th WAIT cycle, i.e. when the counter
    // (which starts at 0 in the first WAIT cycle) holds TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          owner_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [7:0]          mem_din_reg;
    logic                mem_rnw_reg;
    logic [15:0]         wait_cnt_reg;
    logic [7:0]          cpu_dout_reg;
    logic                err_timeout_reg;
    logic [7:0]          starve_cnt_reg;
    logic [7:0]          starve_cnt_next;
    logic                rr_ptr_reg;       // 0 = flash next, 1 = loader next

    // ---------------------------------------------------------------------
    // Winner selection (evaluated every cycle, used only in IDLE)
    // ---------------------------------------------------------------------
    logic                any_req;
    logic                others_pending;
    logic                cpu_blocked;
    logic [1:0]          sel_owner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [7:0]          sel_din;
    logic                sel_rnw;
    logic                timeout_hit;
    logic                cpu_read_owner;

    assign any_req        = cpu_req | flash_req | ld_req;
    assign others_pending = flash_req | ld_req;
    // The CPU is skipped only if someone else can actually take the slot;
    // otherwise a lone CPU request would stall the port.
    assign cpu_blocked    = others_pending && (starve_cnt_reg == STARVE_LIM);
    assign timeout_hit    = (wait_cnt_reg == WAIT_LAST);
    assign cpu_read_owner = (owner_reg == OWN_CPU) && mem_rnw_reg;

    always_comb begin
        sel_owner = OWN_CPU;
        sel_addr  = cpu_addr;
        sel_din   = cpu_din;
        sel_rnw   = cpu_rnw;
        if (cpu_req && !cpu_blocked) begin
            sel_owner = OWN_CPU;
        end else if (flash_req && (!ld_req || !rr_ptr_reg)) begin
            sel_owner = OWN_FLASH;
            sel_addr  = flash_addr;
            sel_din   = flash_din;
            sel_rnw   = 1'b0;
        end else if (ld_req) begin
            sel_owner = OWN_LD;
            sel_addr  = ld_addr;
            sel_din   = ld_din;
            sel_rnw   = 1'b0;
        end
    end

    // Starvation counter update for the grant being made this cycle.
    always_comb begin
        starve_cnt_next = 8'd0;
        if (sel_owner == OWN_CPU && others_pending) begin
            if (starve_cnt_reg != STARVE_LIM) begin
                starve_cnt_next = starve_cnt_reg + 8'd1;
            end else begin
                starve_cnt_next = starve_cnt_reg;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and strobes (all strobes decode the state register,
    // so they are glitch-free single-cycle pulses)
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        mem_ce      = 1'b0;
        flash_ready = 1'b0;
        cpu_done    = 1'b0;
        flash_done  = 1'b0;
        ld_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_ce      = 1'b1;
                flash_ready = (owner_reg == OWN_FLASH);
                state_next  = WAIT;
            end
            WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_done   = (owner_reg == OWN_CPU);
                flash_done = (owner_reg == OWN_FLASH);
                ld_done    = (owner_reg == OWN_LD);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: latch on grant, count WAIT cycles, capture read data
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg       <= OWN_CPU;
            mem_addr_reg    <= '0;
            mem_din_reg     <= 8'h00;
            mem_rnw_reg     <= 1'b1;
            wait_cnt_reg    <= 16'd0;
            cpu_dout_reg    <= 8'hFF;
            err_timeout_reg <= 1'b0;
            starve_cnt_reg  <= 8'd0;
            rr_ptr_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        owner_reg      <= sel_owner;
                        mem_addr_reg   <= sel_addr;
                        mem_din_reg    <= sel_din;
                        mem_rnw_reg    <= sel_rnw;
                        starve_cnt_reg <= starve_cnt_next;
                        if (sel_owner != OWN_CPU) begin
                            rr_ptr_reg <= ~rr_ptr_reg;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= 16'd0;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    // An ack in the timeout cycle wins: data taken, no error.
                    if (mem_ack) begin
                        if (cpu_read_owner) begin
                            cpu_dout_reg <= mem_dout;
                        end
                    end else if (timeout_hit) begin
                        err_timeout_reg <= 1'b1;
                        if (cpu_read_owner) begin
                            cpu_dout_reg <= 8'hFF;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr    = mem_addr_reg;
    assign mem_din     = mem_din_reg;
    assign mem_rnw     = mem_rnw_reg;
    assign cpu_dout    = cpu_dout_reg;
    assign err_timeout = err_timeout_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_msx_mem_arbiter
//
// Directed bench for msx_mem_arbiter (STARVE_MAX=8, TIMEOUT=15). Stimulus
// pushes the expected issue and completion records into queues; a monitor
// pops and compares on every mem_ce strobe and every done pulse. A small
// controller model answers mem_ce with mem_ack after a programmable number
// of WAIT cycles (0 = never).
// -----------------------------------------------------------------------------
module tb_msx_mem_arbiter;

    localparam int AW = 27;
    localparam logic [1:0] O_CPU = 2'd0;
    localparam logic [1:0] O_FL  = 2'd1;
    localparam logic [1:0] O_LD  = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_rnw, flash_req, ld_req;
    logic [AW-1:0] cpu_addr, flash_addr, ld_addr;
    logic [7:0]    cpu_din, flash_din, ld_din;
    logic [7:0]    cpu_dout;
    logic          cpu_done, flash_ready, flash_done, ld_done;
    logic          mem_ce, mem_rnw, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din, mem_dout;
    logic          busy, err_timeout;

    msx_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .cpu_done(cpu_done),
        .flash_req(flash_req), .flash_addr(flash_addr), .flash_din(flash_din),
        .flash_ready(flash_ready), .flash_done(flash_done),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_done(ld_done),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_rnw(mem_rnw), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    owner;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic          rnw;
    } issue_t;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] dout;
    } done_t;

    issue_t issue_q[$];
    done_t  done_q[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   last_done_cyc = 0;
    int   ack_delay = 1;
    int   stray_req = 0;
    logic [7:0] resp_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_issue(input logic [1:0] o, input logic [AW-1:0] a,
                              input logic [7:0] d, input logic r);
        issue_t e;
        e.owner = o; e.addr = a; e.din = d; e.rnw = r;
        issue_q.push_back(e);
    endtask

    task automatic push_done(input logic [1:0] o, input logic [7:0] d);
        done_t e;
        e.owner = o; e.dout = d;
        done_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target, input int limit, input string name);
        int n = 0;
        while (done_count < target && n < limit) begin
            tick();
            n++;
        end
        check(name, done_count, target);
    endtask

    // Memory controller model: ack arrives in the ack_delay-th WAIT cycle.
    initial begin
        int countdown = 0;
        int stray_seen = 0;
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    mem_ack  = 1'b1;
                    mem_dout = resp_data;
                end
            end
            if (stray_seen != stray_req) begin
                stray_seen = stray_req;
                mem_ack  = 1'b1;
                mem_dout = resp_data;
            end
            if (mem_ce && ack_delay > 0) countdown = ack_delay;
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ce) begin
                if (issue_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: addr=%0h rnw=%b", mem_addr, mem_rnw);
                end else begin
                    issue_t e;
                    e = issue_q.pop_front();
                    $display("issue  cyc=%0d addr=%07h din=%02h rnw=%b flash_ready=%b",
                             cyc, mem_addr, mem_din, mem_rnw, flash_ready);
                    check("issue_addr", 32'(mem_addr), 32'(e.addr));
                    check("issue_din", 32'(mem_din), 32'(e.din));
                    check("issue_rnw", 32'(mem_rnw), 32'(e.rnw));
                    check("issue_flash_ready", 32'(flash_ready), 32'(e.owner == O_FL));
                end
            end else if (flash_ready) begin
                checks++; errors++;
                $display("FAIL stray_flash_ready: got=1 expected=0");
            end
            if (cpu_done || flash_done || ld_done) begin
                logic [2:0] got_vec;
                got_vec = {ld_done, flash_done, cpu_done};
                done_count++;
                last_done_cyc = cyc;
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got=%b expected=none", got_vec);
                end else begin
                    done_t e;
                    logic [2:0] exp_vec;
                    e = done_q.pop_front();
                    exp_vec = 3'b001 << e.owner;
                    $display("done   cyc=%0d owners(ld,fl,cpu)=%b cpu_dout=%02h err=%b",
                             cyc, got_vec, cpu_dout, err_timeout);
                    check("done_owner", 32'(got_vec), 32'(exp_vec));
                    check("done_cpu_dout", 32'(cpu_dout), 32'(e.dout));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int base;
        int req_cyc;
        reset = 1'b1;
        cpu_req = 0; cpu_rnw = 1; cpu_addr = '0; cpu_din = 0;
        flash_req = 0; flash_addr = '0; flash_din = 0;
        ld_req = 0; ld_addr = '0; ld_din = 0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_din", 32'(mem_din), 0);
        check("rst_mem_rnw", 32'(mem_rnw), 1);
        check("rst_pulses", 32'({mem_ce, cpu_done, flash_ready, flash_done, ld_done}), 0);
        reset = 1'b0;
        tick();

        // 1: single CPU read, minimum latency
        cpu_addr = 27'h01234; cpu_din = 8'h00; cpu_rnw = 1'b1;
        resp_data = 8'hA5; ack_delay = 1;
        push_issue(O_CPU, 27'h01234, 8'h00, 1'b1);
        push_done(O_CPU, 8'hA5);
        base = done_count; req_cyc = cyc; cpu_req = 1'b1;
        wait_dones(base + 1, 20, "cpu_read_done");
        cpu_req = 1'b0;
        check("cpu_read_latency", 32'(last_done_cyc - req_cyc), 3);

        // 2: flash/loader round robin
        flash_addr = 27'h2ABCDE; flash_din = 8'h11;
        ld_addr = 27'h0001000; ld_din = 8'h22;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                push_issue(O_FL, 27'h2ABCDE, 8'h11, 1'b0);
                push_done(O_FL, 8'hA5);
            end else begin
                push_issue(O_LD, 27'h0001000, 8'h22, 1'b0);
                push_done(O_LD, 8'hA5);
            end
        end
        base = done_count; flash_req = 1'b1; ld_req = 1'b1;
        wait_dones(base + 4, 40, "rr_done");
        flash_req = 1'b0; ld_req = 1'b0;
        tick();

        // 3: starvation guard: 8 CPU grants, one loader, then CPU
        cpu_addr = 27'h0000040; cpu_din = 8'h5A; cpu_rnw = 1'b0;
        ld_addr = 27'h0003000; ld_din = 8'h33;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                push_issue(O_LD, 27'h0003000, 8'h33, 1'b0);
                push_done(O_LD, 8'hA5);
            end else begin
                push_issue(O_CPU, 27'h0000040, 8'h5A, 1'b0);
                push_done(O_CPU, 8'hA5);
            end
        end
        base = done_count; cpu_req = 1'b1; ld_req = 1'b1;
        wait_dones(base + 10, 80, "starve_done");
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();

        // 4: timeout, then a normal access
        check("pre_timeout_err", 32'(err_timeout), 0);
        cpu_addr = 27'h0000777; cpu_din = 8'h00; cpu_rnw = 1'b1; ack_delay = 0;
        push_issue(O_CPU, 27'h0000777, 8'h00, 1'b1);
        push_done(O_CPU, 8'hFF);
        base = done_count; req_cyc = cyc; cpu_req = 1'b1;
        wait_dones(base + 1, 40, "timeout_done");
        cpu_req = 1'b0;
        check("timeout_latency", 32'(last_done_cyc - req_cyc), 17);
        check("timeout_err_set", 32'(err_timeout), 1);
        tick();
        cpu_addr = 27'h0000100; ack_delay = 1; resp_data = 8'h42;
        push_issue(O_CPU, 27'h0000100, 8'h00, 1'b1);
        push_done(O_CPU, 8'h42);
        base = done_count; cpu_req = 1'b1;
        wait_dones(base + 1, 20, "post_timeout_done");
        cpu_req = 1'b0;
        check("timeout_err_sticky", 32'(err_timeout), 1);

        // 5: ack on the timeout cycle wins; stray ack in IDLE ignored
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("reset_clears_err", 32'(err_timeout), 0);
        check("reset_cpu_dout", 32'(cpu_dout), 32'hFF);
        cpu_addr = 27'h0000ABC; ack_delay = 15; resp_data = 8'h3C;
        push_issue(O_CPU, 27'h0000ABC, 8'h00, 1'b1);
        push_done(O_CPU, 8'h3C);
        base = done_count; req_cyc = cyc; cpu_req = 1'b1;
        wait_dones(base + 1, 40, "tie_done");
        cpu_req = 1'b0;
        check("tie_latency", 32'(last_done_cyc - req_cyc), 17);
        check("tie_err", 32'(err_timeout), 0);
        tick();
        ack_delay = 0; resp_data = 8'h77;
        base = done_count; stray_req++;
        repeat (4) tick();
        check("stray_no_done", 32'(done_count), 32'(base));
        check("stray_busy", 32'(busy), 0);
        check("stray_cpu_dout", 32'(cpu_dout), 32'h3C);

        // 6: reset while in WAIT, late ack ignored, next request serviced
        cpu_addr = 27'h0000555;
        push_issue(O_CPU, 27'h0000555, 8'h00, 1'b1);
        base = done_count; cpu_req = 1'b1;
        tick();          // ISSUE
        tick();          // WAIT
        check("wait_busy", 32'(busy), 1);
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        check("midrst_mem_rnw", 32'(mem_rnw), 1);
        check("midrst_cpu_dout", 32'(cpu_dout), 32'hFF);
        check("midrst_pulses", 32'({mem_ce, cpu_done, flash_ready, flash_done, ld_done}), 0);
        reset = 1'b0;
        stray_req++;
        repeat (4) tick();
        check("midrst_no_done", 32'(done_count), 32'(base));
        check("midrst_idle", 32'(busy), 0);
        flash_addr = 27'h0004444; flash_din = 8'h99; ack_delay = 1;
        push_issue(O_FL, 27'h0004444, 8'h99, 1'b0);
        push_done(O_FL, 8'hFF);
        flash_req = 1'b1;
        wait_dones(base + 1, 20, "after_reset_done");
        flash_req = 1'b0;
        repeat (3) tick();

        check("issue_queue_empty", 32'(issue_q.size()), 0);
        check("done_queue_empty", 32'(done_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
